// File: rtl/bit_slice_1bit_if.sv
// bit_slice_1bit_if: operand, opcode and result signals of one ALU bit slice
interface bit_slice_1bit_if;
  logic       a;
  logic       b;
  logic       cin;
  logic [2:0] ctrl;
  logic       res;
  logic       cout;
  modport master (output a, b, cin, ctrl, input res, cout);
  modport slave  (input a, b, cin, ctrl, output res, cout);
endinterface

// File: rtl/bit_slice_1bit.sv
// bit_slice_1bit: one ALU bit with a registered result and a combinational ripple carry
module bit_slice_1bit (
  input logic             clk,
  input logic             reset_n,
  bit_slice_1bit_if.slave bus
);
  logic bb, s, c, arith, out_d, out_q;
  always_comb begin
    bb    = bus.b ^ (bus.ctrl[0] & ~bus.ctrl[2]);
    s     = bus.a ^ bb ^ bus.cin;
    c     = (bus.a & bb) | (bus.a & bus.cin) | (bb & bus.cin);
    arith = ~bus.ctrl[2] & ~(bus.ctrl[1] & ~bus.ctrl[0]);
    out_d = bus.ctrl[2] ? (bus.ctrl[1] ? (bus.ctrl[0] ? ~(bus.a | bus.b) : (bus.a | bus.b))
                                       : (bus.ctrl[0] ? ~(bus.a & bus.b) : (bus.a & bus.b)))
                        : (arith ? s : (bus.a ^ bus.b));
  end
  always_ff @(posedge clk)
    out_q <= reset_n ? out_d : 1'b0;
  assign bus.res  = out_q;
  assign bus.cout = arith & c;
endmodule

// File: tb/tb_bit_slice_1bit.sv
// tb_bit_slice_1bit: directed checks of a single slice and a two-slice ripple chain
module tb_bit_slice_1bit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  bit_slice_1bit_if bus0 ();
  bit_slice_1bit_if bus1 ();
  bit_slice_1bit dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  bit_slice_1bit dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  assign bus1.cin = bus0.cout;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input logic cin, input logic [2:0] ctrl);
    bus0.a = a; bus0.b = b; bus0.cin = cin; bus0.ctrl = ctrl;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.ctrl = 3'b110;
    drive(1'b1, 1'b1, 1'b0, 3'b110);
    tick();
    total++; if (bus0.res !== 1'b0) begin bad++; $display("FAIL reset_out got=%b exp=0", bus0.res); end
    total++; if (bus0.cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", bus0.cout); end
    total++; if (bus1.res !== 1'b0) begin bad++; $display("FAIL reset_out1 got=%b exp=0", bus1.res); end
  endtask

  task automatic test_add();
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 3'b000);
    total++; if (bus0.cout !== 1'b1) begin bad++; $display("FAIL add_cout got=%b exp=1", bus0.cout); end
    total++; if (bus0.res !== 1'b0) begin bad++; $display("FAIL add_out_pre_edge got=%b exp=0", bus0.res); end
    tick();
    total++; if (bus0.res !== 1'b1) begin bad++; $display("FAIL add_out got=%b exp=1", bus0.res); end
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    tick();
    total++; if (bus0.res !== 1'b0) begin bad++; $display("FAIL add2_out got=%b exp=0", bus0.res); end
    total++; if (bus0.cout !== 1'b1) begin bad++; $display("FAIL add2_cout got=%b exp=1", bus0.cout); end
  endtask

  task automatic test_sub();
    drive(1'b0, 1'b1, 1'b1, 3'b001);
    total++; if (bus0.cout !== 1'b0) begin bad++; $display("FAIL sub1_cout got=%b exp=0", bus0.cout); end
    tick();
    total++; if (bus0.res !== 1'b1) begin bad++; $display("FAIL sub1_out got=%b exp=1", bus0.res); end
    drive(1'b1, 1'b1, 1'b1, 3'b001);
    tick();
    total++; if (bus0.res !== 1'b0) begin bad++; $display("FAIL sub2_out got=%b exp=0", bus0.res); end
    total++; if (bus0.cout !== 1'b1) begin bad++; $display("FAIL sub2_cout got=%b exp=1", bus0.cout); end
  endtask

  task automatic test_slt();
    drive(1'b0, 1'b0, 1'b1, 3'b011);
    tick();
    total++; if (bus0.res !== 1'b0) begin bad++; $display("FAIL slt1_out got=%b exp=0", bus0.res); end
    total++; if (bus0.cout !== 1'b1) begin bad++; $display("FAIL slt1_cout got=%b exp=1", bus0.cout); end
    drive(1'b0, 1'b0, 1'b0, 3'b011);
    tick();
    total++; if (bus0.res !== 1'b1) begin bad++; $display("FAIL slt2_out got=%b exp=1", bus0.res); end
    total++; if (bus0.cout !== 1'b0) begin bad++; $display("FAIL slt2_cout got=%b exp=0", bus0.cout); end
  endtask

  task automatic test_logic();
    logic [2:0] ops [5] = '{3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
    logic       e10 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       e11 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, ops[i]);
      tick();
      total++; if (bus0.res !== e10[i]) begin bad++; $display("FAIL logic10_out ctrl=%b got=%b exp=%b", ops[i], bus0.res, e10[i]); end
      total++; if (bus0.cout !== 1'b0) begin bad++; $display("FAIL logic10_cout ctrl=%b got=%b exp=0", ops[i], bus0.cout); end
      drive(1'b1, 1'b1, 1'b1, ops[i]);
      tick();
      total++; if (bus0.res !== e11[i]) begin bad++; $display("FAIL logic11_out ctrl=%b got=%b exp=%b", ops[i], bus0.res, e11[i]); end
      total++; if (bus0.cout !== 1'b0) begin bad++; $display("FAIL logic11_cout ctrl=%b got=%b exp=0", ops[i], bus0.cout); end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b0, 1'b0, 3'b000);
    tick();
    total++; if (bus0.res !== 1'b1) begin bad++; $display("FAIL hold_load got=%b exp=1", bus0.res); end
    drive(1'b1, 1'b1, 1'b1, 3'b000);
    total++; if (bus0.res !== 1'b1) begin bad++; $display("FAIL hold_out got=%b exp=1", bus0.res); end
    total++; if (bus0.cout !== 1'b1) begin bad++; $display("FAIL hold_cout got=%b exp=1", bus0.cout); end
  endtask

  task automatic test_chain();
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.ctrl = 3'b000;
    #1;
    total++; if (bus1.cout !== 1'b1) begin bad++; $display("FAIL chain_cout1 got=%b exp=1", bus1.cout); end
    tick();
    total++; if ({bus1.res, bus0.res} !== 2'b00) begin bad++; $display("FAIL chain_outs got=%b exp=00", {bus1.res, bus0.res}); end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 1'b0, 3'b000);
    tick();
    total++; if (bus0.res !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", bus0.res); end
    reset_n = 1'b0;
    tick();
    total++; if (bus0.res !== 1'b0) begin bad++; $display("FAIL midrst_out got=%b exp=0", bus0.res); end
    drive(1'b1, 1'b0, 1'b1, 3'b000);
    total++; if (bus0.cout !== 1'b1) begin bad++; $display("FAIL midrst_cout got=%b exp=1", bus0.cout); end
    drive(1'b1, 1'b0, 1'b0, 3'b000);
    reset_n = 1'b1;
    tick();
    total++; if (bus0.res !== 1'b1) begin bad++; $display("FAIL midrst_release got=%b exp=1", bus0.res); end
  endtask

  initial begin
    #2;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_hold();
    test_chain();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bit_slice_1bit.md
BIT_SLICE_1BIT -- requirements
Module: bitSlice_1bit

Interface
REQ-001 Parameters SHALL be none.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 A  input  1  operand A bit.
REQ-005 B  input  1  operand B bit.
REQ-006 Cin  input  1  carry-in (LSB slice: tied to Ctrl[0]; others: previous slice Cout).
REQ-007 Ctrl  input  3  operation select.
REQ-008 Out  output  1  registered result bit.
REQ-009 Cout  output  1  combinational carry-out for the ripple chain.

Function
REQ-010 Bb (effective B) SHALL be B XOR (Ctrl==001 or Ctrl==011); B is inverted for SUB and SLT only.
REQ-011 Full-adder terms: S = A^Bb^Cin; C = (A&Bb)|(A&Cin)|(Bb&Cin).
REQ-012 Next-Out per Ctrl: 000 ADD -> S; 001 SUB -> S; 010 XOR -> A^B; 011 SLT -> S (difference bit; the parent selects the sign for the SLT result); 100 MUL -> A&B (1-bit partial product); 101 NAND -> ~(A&B); 110 OR -> A|B; 111 NOR -> ~(A|B).
REQ-013 Cout SHALL equal C for Ctrl 000, 001 and 011, and 0 for every other Ctrl value.
REQ-014 Cout SHALL be purely combinational (zero-cycle path from A, B, Cin and Ctrl), so slices can be chained without pipeline registers.
REQ-015 Out SHALL be registered: the value computed from inputs sampled at rising edge N SHALL appear at Out after edge N (latency 1 cycle).
REQ-016 Inputs changing between edges SHALL affect only Cout and SHALL NOT affect Out until the next edge.
REQ-017 Ctrl change and operand change on the same edge SHALL be treated as one new operation, using the new values together.
REQ-018 X/Z on inputs SHALL NOT be masked; the design has no undefined opcodes.

Reset
REQ-019 While reset_n=0 at a rising edge, Out SHALL become 0 on that edge.
REQ-020 Reset SHALL take priority over computation; an operation presented on a reset edge SHALL be discarded.
REQ-021 Cout SHALL be unaffected by reset and SHALL keep tracking its inputs during reset.
REQ-022 The first edge with reset_n=1 SHALL load the normal result (no extra recovery cycle).

Verification
REQ-023 Reset: reset_n=0, A=1, B=1, Ctrl=110, one edge -> Out=0; Cout=0.
REQ-024 ADD: Ctrl=000, A=1, B=1, Cin=1 -> Cout=1 immediately; Out=1 after the next edge.
REQ-025 SUB: Ctrl=001, A=0, B=1, Cin=1 -> Bb=0; Cout=0; Out=1 after the edge. Also A=1, B=1, Cin=1 -> Out=0, Cout=1.
REQ-026 Logic ops with A=1, B=0, Cin=1: XOR -> Out=1, Cout=0; MUL -> Out=0; NAND -> Out=1; OR -> Out=1; NOR -> Out=0; Cout=0 for every case.
REQ-027 Chain: two instances rippled (Cout0->Cin1), Ctrl=000, A=11b, B=01b, Cin0=0 -> Outs=00b after one edge; Cout1=1.
REQ-028 Mid-operation reset: hold Ctrl=000, A=1, B=0, Cin=0 (Out=1), then assert reset_n=0 for one edge -> Out=0; release -> Out=1 on the next edge.
